// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a simple multi-cycle CPU.
//
// Walks a fetch sequence (T0..T2) and an opcode-dependent execute sequence
// (T3..T5), asserting one-hot style datapath controls for each step. T1
// waits for memory and gives up after MEM_WAIT extra cycles, entering HALT
// with a sticky fault flag.
//
// Ports:
//   clock       sole clock, rising edge
//   clear       synchronous active-high reset
//   ir_opcode   IR[31:27], decoded in T3 only
//   mem_ready   memory read data valid this cycle
//   PCout..IRin fetch controls
//   Gra..LOout  execute controls
//   operation   ALU opcode (ALU_ADD in T4 of ADDI, else 0)
//   step        state code: Default=0, T0..T5=1..6, HALT=15
//   run         high in every state except Default and HALT
//   fault       sticky memory-timeout flag
//   illegal_op  one-cycle pulse on an undefined opcode in T3
module control_sequencer #(
    parameter int               OPC_W    = 5,
    parameter int               MEM_WAIT = 15,
    parameter logic [OPC_W-1:0] OP_ADDI  = 5'b01100,
    parameter logic [OPC_W-1:0] OP_JR    = 5'b10100,
    parameter logic [OPC_W-1:0] OP_IN    = 5'b10110,
    parameter logic [OPC_W-1:0] OP_OUT   = 5'b10111,
    parameter logic [OPC_W-1:0] OP_MFHI  = 5'b11000,
    parameter logic [OPC_W-1:0] OP_MFLO  = 5'b11001,
    parameter logic [OPC_W-1:0] OP_NOP   = 5'b11010,
    parameter logic [OPC_W-1:0] OP_HALT  = 5'b11011,
    parameter logic [4:0]       ALU_ADD  = 5'b00011
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zlowin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             MDRin,
    output logic             read,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             Rin,
    output logic             Rout,
    output logic             Yin,
    output logic             Cout,
    output logic             Inportout,
    output logic             OutPortin,
    output logic             HIout,
    output logic             LOout,
    output logic [4:0]       operation,
    output logic [3:0]       step,
    output logic             run,
    output logic             fault,
    output logic             illegal_op
);

    localparam int WAIT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_DEFAULT = 4'd0,
        S_T0      = 4'd1,
        S_T1      = 4'd2,
        S_T2      = 4'd3,
        S_T3      = 4'd4,
        S_T4      = 4'd5,
        S_T5      = 4'd6,
        S_HALT    = 4'd15
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_DEFAULT;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            fault <= fault | timeout;
            // Counter only advances while T1 is held; any exit from T1 zeroes it.
            if (state == S_T1 && state_next == S_T1)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zlowin     = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        read       = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        Inportout  = 1'b0;
        OutPortin  = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        operation  = '0;
        illegal_op = 1'b0;

        unique case (state)
            S_DEFAULT: state_next = S_T0;
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zlowin     = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                read  = 1'b1;
                MDRin = 1'b1;
                // PC update happens once, on entry, not on every wait cycle.
                if (wait_cnt == '0) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                // Data arriving on the last allowed cycle still wins over timeout.
                if (mem_ready) begin
                    state_next = S_T2;
                end else if (wait_cnt == WAIT_MAX) begin
                    state_next = S_HALT;
                    timeout    = 1'b1;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                state_next = S_T0;
                if (ir_opcode == OP_IN) begin
                    Gra = 1'b1; Rin = 1'b1; Inportout = 1'b1;
                end else if (ir_opcode == OP_OUT) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
                end else if (ir_opcode == OP_MFHI) begin
                    Gra = 1'b1; Rin = 1'b1; HIout = 1'b1;
                end else if (ir_opcode == OP_MFLO) begin
                    Gra = 1'b1; Rin = 1'b1; LOout = 1'b1;
                end else if (ir_opcode == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (ir_opcode == OP_ADDI) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_next = S_T4;
                end else if (ir_opcode == OP_NOP) begin
                    state_next = S_T0;
                end else if (ir_opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            S_T4: begin
                Cout       = 1'b1;
                Zlowin     = 1'b1;
                operation  = ALU_ADD;
                state_next = S_T5;
            end
            S_T5: begin
                Zlowout    = 1'b1;
                Gra        = 1'b1;
                Rin        = 1'b1;
                state_next = S_T0;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_DEFAULT;
        endcase
    end

    assign step = state;
    assign run  = (state != S_DEFAULT) && (state != S_HALT);

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPC_W, default 5: opcode field width.
REQ-002 Parameter MEM_WAIT, default 15: maximum T1 wait cycles before fault.
REQ-003 Parameters OP_ADDI=01100, OP_JR=10100, OP_IN=10110, OP_OUT=10111, OP_MFHI=11000, OP_MFLO=11001, OP_NOP=11010, OP_HALT=11011, ALU_ADD=00011: opcode and ALU codes.
REQ-004 clock  in  1  sole clock; all state changes on rising edge.
REQ-005 clear  in  1  reset, synchronous, active-high.
REQ-006 ir_opcode  in  OPC_W  IR[31:27], valid from T3 onward.
REQ-007 mem_ready  in  1  memory read data valid this cycle.
REQ-008 PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDRin, read, MDRout, IRin  out  1 each  fetch controls.
REQ-009 Gra, Grb, Rin, Rout, Yin, Cout, Inportout, OutPortin, HIout, LOout  out  1 each  execute controls.
REQ-010 operation  out  5  ALU opcode; 0 except T4 of ADDI.
REQ-011 step  out  4  state code: Default=0, T0..T5=1..6, HALT=15.
REQ-012 run  out  1  1 in every state except Default and HALT.
REQ-013 fault  out  1  sticky memory-timeout flag.
REQ-014 illegal_op  out  1  one-cycle pulse on undefined opcode in T3.

Function
REQ-015 Outputs SHALL be combinational decodes of state register, T1 wait counter and ir_opcode; no output asserted outside the listed steps.
REQ-016 Default -> T0 after one cycle.
REQ-017 T0: PCout, MARin, IncPC, Zlowin; -> T1.
REQ-018 T1: read and MDRin held every T1 cycle; Zlowout and PCin only on first T1 cycle (wait count 0).
REQ-019 T1 with mem_ready=1 -> T2; with mem_ready=0 -> stay, wait counter +1.
REQ-020 Wait counter cleared on T1 exit and on clear; width ceil(log2(MEM_WAIT+1)).
REQ-021 T1 with mem_ready=0 and counter==MEM_WAIT -> HALT, fault set; mem_ready=1 in same cycle wins (-> T2, no fault).
REQ-022 T2: MDRout, IRin; -> T3.
REQ-023 T3 IN: Gra, Rin, Inportout; -> T0.
REQ-024 T3 OUT: Gra, Rout, OutPortin; -> T0.
REQ-025 T3 MFHI: Gra, Rin, HIout; MFLO: Gra, Rin, LOout; -> T0.
REQ-026 T3 JR: Gra, Rout, PCin; -> T0.
REQ-027 ADDI: T3 Grb, Rout, Yin -> T4; T4 Cout, Zlowin, operation=ALU_ADD -> T5; T5 Zlowout, Gra, Rin -> T0.
REQ-028 T3 NOP: no controls; -> T0.
REQ-029 T3 HALT: no controls; -> HALT.
REQ-030 T3 undefined opcode: illegal_op=1 that cycle, no other controls; -> T0.
REQ-031 HALT: all controls 0, run=0; held until clear.
REQ-032 ir_opcode SHALL be ignored in Default, T0, T1, T2, HALT.

Reset
REQ-033 clear=1 at a rising edge SHALL force state Default, wait counter 0, fault 0 on that edge, overriding any in-progress step or wait.
REQ-034 While state is Default all control outputs, operation, run and illegal_op SHALL be 0, step=0.
REQ-035 Deasserting clear SHALL give Default for one cycle, then T0.

Verification
REQ-036 clear 1 cycle, mem_ready=1, ir_opcode=10110 -> steps 0,1,2,3,4,1; T3 Gra=Rin=Inportout=1; loop repeats every 4 cycles.
REQ-037 ir_opcode=01100, mem_ready=1 -> T3 Grb/Rout/Yin, T4 operation=00011 with Cout/Zlowin, T5 Zlowout/Gra/Rin; 6-cycle loop.
REQ-038 mem_ready=0 for 3 cycles then 1 -> T1 lasts 4 cycles, PCin only first cycle, read held all 4, no fault.
REQ-039 mem_ready stuck 0, MEM_WAIT=15 -> 16 T1 cycles, then step=15, fault=1, run=0, stays until clear; clear -> fault=0, step=0.
REQ-040 ir_opcode=00000 -> illegal_op pulse one cycle in T3, next step=1; ir_opcode=11011 -> step=15, run=0.
REQ-041 clear asserted mid-T4 of ADDI -> next cycle step=0, operation=0, all controls 0.
